// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-to-binary decoder.
// Holds the decoder FSM state type and the window-length derivation
// (a window is 2^N accepted bitstream samples).
package sc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Number of accepted samples in one window for a given log2 length.
    function automatic int unsigned win_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/sc_to_bin_if.sv
// Bitstream / result bundle for sc_to_bin.
// master: drives start, bit_in, bit_valid; observes result, result_valid, busy.
// slave : the decoder side.
interface sc_to_bin_if #(
    parameter int unsigned N = 2
) ();

    logic         start;
    logic         bit_in;
    logic         bit_valid;
    logic [N:0]   result;
    logic         result_valid;
    logic         busy;

    modport master (
        output start, bit_in, bit_valid,
        input  result, result_valid, busy
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output result, result_valid, busy
    );

endinterface

// File: rtl/s2b_window_ctr.sv
// Window sample counter for sc_to_bin.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   clear        : synchronous clear (priority over enable)
//   en           : count one accepted sample
//   count        : N+1-bit sample count (reaches 2^N without wrapping)
//   tc           : terminal count -- the next accepted sample completes the window
module s2b_window_ctr
    import sc_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    output logic [N:0] count,
    output logic       tc
);

    localparam logic [N:0] LastIdx = (N + 1)'(win_len(N) - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Deliberately not qualified by en so the top can gate it without a comb loop.
    assign tc = (count == LastIdx);

endmodule

// File: rtl/sc_to_bin.sv
// Stochastic bitstream to binary decoder.
// Counts the ones in a window of 2^N valid samples after a start request and
// publishes the decoded value with a one-cycle result_valid pulse.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   bus (slave)  : start, bit_in, bit_valid in; result, result_valid, busy out
// Configuration:
//   SC_BIPOLAR_EN undefined -> result = ones count (unsigned, 0..2^N)
//   SC_BIPOLAR_EN defined   -> result = 2*ones - 2^N, two's complement,
//                              saturated to 2^N-1 for an all-ones window
module sc_to_bin
    import sc_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input logic         clock,
    input logic         reset,
    sc_to_bin_if.slave  bus
);

    localparam logic [N:0] WinVal = (N + 1)'(win_len(N));

    state_e     state_q, state_d;
    logic [N:0] ones_q, ones_d;
    logic [N:0] result_q, result_d;
    logic [N:0] sample_cnt;
    logic       at_last;
    logic       cnt_clear;
    logic       accept;

    function automatic logic [N:0] encode(input logic [N:0] ones);
`ifdef SC_BIPOLAR_EN
        logic [N+1:0] dbl;
        dbl = {ones, 1'b0} - {1'b0, WinVal};
        // +2^N is not representable in N+1 bits; clamp to the largest positive.
        if (ones == WinVal) begin
            return {1'b0, {N{1'b1}}};
        end
        return dbl[N:0];
`else
        return ones;
`endif
    endfunction

    s2b_window_ctr #(
        .N (N)
    ) u_window_ctr (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .en    (accept),
        .count (sample_cnt),
        .tc    (at_last)
    );

    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        result_d  = result_q;
        cnt_clear = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StAccum;
                    cnt_clear = 1'b1;
                    ones_d    = '0;
                end
            end
            StAccum: begin
                // start beats any sample in the same cycle, including the last one.
                if (bus.start) begin
                    cnt_clear = 1'b1;
                    ones_d    = '0;
                end else if (bus.bit_valid) begin
                    accept = 1'b1;
                    ones_d = ones_q + {{N{1'b0}}, bus.bit_in};
                    if (at_last) begin
                        state_d  = StDone;
                        result_d = encode(ones_d);
                    end
                end
            end
            StDone: begin
                if (bus.start) begin
                    state_d   = StAccum;
                    cnt_clear = 1'b1;
                    ones_d    = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ones_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            result_q <= result_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = (state_q == StDone);
    assign bus.busy         = (state_q == StAccum);

    sample_cnt_bound: assert property (@(posedge clock) disable iff (reset)
        sample_cnt <= WinVal);

endmodule

// File: doc/sc_to_bin.md
SC_TO_BIN -- requirements
Module: sc_to_bin

Interface
REQ-001 SHALL have parameter N, default 2, meaning log2 of the window length; each window is 2^N accepted stochastic bits.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: synchronous request to clear and begin a new window.
REQ-005 SHALL have port bit_in, input, 1 bit: stochastic bitstream sample.
REQ-006 SHALL have port bit_valid, input, 1 bit: qualifies bit_in; bit_in is ignored when low.
REQ-007 SHALL have port result, output, N+1 bits: decoded binary value of the last completed window.
REQ-008 SHALL have port result_valid, output, 1 bit: one-cycle pulse when result updates.
REQ-009 SHALL have port busy, output, 1 bit: high while a window is being accumulated.

Function
REQ-010 SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-011 IDLE: busy=0 and result_valid=0; start=1 -> ACCUM, with the sample count and the ones count cleared.
REQ-012 SHALL NOT sample bit_in in the cycle where start is asserted; sampling begins the following cycle.
REQ-013 ACCUM: each cycle with bit_valid=1 SHALL increment the sample count, and SHALL increment the ones count when bit_in=1.
REQ-014 SHALL use N+1-bit counts so that an all-ones window (2^N) is representable without wrap.
REQ-015 ACCUM -> DONE in the cycle the 2^N-th valid sample is accepted; result SHALL be registered on that edge.
REQ-016 DONE: result_valid=1 for exactly one cycle, busy=0; next state is ACCUM if start=1, else IDLE.
REQ-017 Latency: result_valid SHALL be high in the cycle immediately after the cycle carrying the last valid sample.
REQ-018 start=1 during ACCUM SHALL abort the window: counts cleared, no result_valid, remain in ACCUM, and result unchanged.
REQ-019 start and the final valid sample in the same cycle: start SHALL win, the sample is discarded and no result is published.
REQ-020 result SHALL hold its value between completions.

Reset
REQ-021 reset=1 SHALL asynchronously force IDLE, counts=0, result=0, result_valid=0 and busy=0, including mid-window.
REQ-022 The first window after reset deassertion SHALL require a start.

Configuration
REQ-023 Macro SC_BIPOLAR_EN SHALL select the output encoding.
- Undefined: result = ones count, unsigned, range 0..2^N.
- Defined: result = 2*ones - 2^N as N+1-bit two's complement, saturated to 2^N-1 when ones=2^N.

Structure
REQ-024 Package sc_pkg SHALL hold the FSM state enum and the window-length constant derivation.
REQ-025 Sub-module s2b_window_ctr SHALL provide the N+1-bit sample counter with clear, enable and terminal-count flag.

Verification (N=2, window=4)
REQ-026 start, then bits 1,0,1,1 all valid -> result_valid one cycle after the 4th bit, result=3, busy low in that cycle.
REQ-027 start, then bits 1,1,(bit_valid=0 with bit_in=1),1,1 -> result=4 (all-ones, no wrap); the invalid bit is not counted.
REQ-028 start, 2 valid bits, start again, then 0,0,0,1 -> single result_valid, result=1.
REQ-029 reset asserted after 3 valid bits -> immediately result=0, busy=0; no result_valid until a new start plus 4 bits.
REQ-030 start held through DONE -> result_valid pulses once and the next window begins without an IDLE cycle.
REQ-031 SC_BIPOLAR_EN defined: four 0 bits -> result=3'b100 (-4); four 1 bits -> 3'b011 (saturated); bits 1,0,1,0 -> 3'b000.
